// File: rtl/pwm_frame_loader_if.sv
// pwm_frame_loader_if: byte stream from the serial receiver into the frame loader
interface pwm_frame_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    modport master (output rx_data, output rx_valid);
    modport slave  (input rx_data, input rx_valid);
endinterface

// File: rtl/pwm_frame_loader.sv
// pwm_frame_loader: checksummed 8x16-bit duty frames committed atomically to v0..v7
module pwm_frame_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [15:0] RESET_DUTY = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] v0,
  output logic [15:0] v1,
  output logic [15:0] v2,
  output logic [15:0] v3,
  output logic [15:0] v4,
  output logic [15:0] v5,
  output logic [15:0] v6,
  output logic [15:0] v7,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;
  state_t      state;
  logic [3:0]  idx;
  logic [7:0]  sum;
  logic [15:0] shadow [8];
  logic [15:0] v [8];
  logic        tmo_hit;
`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo;
  assign tmo_hit = (state != IDLE) && !rx_valid && (tmo == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clock)
    tmo <= (!reset || state == IDLE || rx_valid || tmo_hit) ? '0 : tmo + 1'b1;
`else
  assign tmo_hit = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      sum       <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= RESET_DUTY;
        v[i]      <= RESET_DUTY;
      end
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= tmo_hit;
      if (tmo_hit) begin
        state <= IDLE;
      end else if (rx_valid) begin
        case (state)
          IDLE: if (rx_data == SYNC_BYTE) begin
            idx   <= '0;
            sum   <= '0;
            state <= PAYLOAD;
          end
          PAYLOAD: begin
            if (idx[0]) shadow[idx[3:1]][7:0] <= rx_data;
            else shadow[idx[3:1]][15:8] <= rx_data;
            sum <= sum + rx_data;
            idx <= idx + 4'd1;
            if (idx == 4'd15) state <= CHECK;
          end
          CHECK: begin
            if (rx_data == sum) begin
              v        <= shadow;
              frame_ok <= 1'b1;
            end else frame_err <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  assign v0   = v[0];
  assign v1   = v[1];
  assign v2   = v[2];
  assign v3   = v[3];
  assign v4   = v[4];
  assign v5   = v[5];
  assign v6   = v[6];
  assign v7   = v[7];
  assign busy = (state != IDLE);
endmodule

// File: doc/pwm_frame_loader.md
Name: pwm_frame_loader

Overview:
Byte-stream frame decoder that sits directly upstream of the 8-channel PWM block and drives its duty inputs v0..v7. It consumes a byte stream from the serial receiver, assembles framed 8x16-bit duty updates into a shadow bank, and checks each frame. All eight duty outputs change together in one cycle, and only when the checksum is correct, so the PWM never sees a half-updated set.

Parameters:
SYNC_BYTE, 8'hA5, start-of-frame marker byte
RESET_DUTY, 16'h0000, value of v0..v7 after reset (0 = all PWM outputs off)
TIMEOUT_CYCLES, 65535, inter-byte timeout in clock cycles; used only with FRAME_TIMEOUT_EN

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets)
rx_data  input  8  received byte, valid when rx_valid=1
rx_valid  input  1  single-cycle strobe, one per byte; may be asserted on back-to-back cycles
v0..v7  output  16 each  committed duty values, registered, to PWM v0..v7
frame_ok  output  1  one-cycle pulse on the cycle the new duties become visible
frame_err  output  1  one-cycle pulse when a frame is discarded
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Frame format: SYNC_BYTE, 16 payload bytes, 1 checksum byte.
- Payload order: ch0 MSB, ch0 LSB, ch1 MSB ... ch7 LSB (big-endian per channel).
- Checksum: 8-bit sum, modulo 256, of the 16 payload bytes. The sync byte is excluded.
- FSM states:
  - IDLE: bytes other than SYNC_BYTE are ignored. On SYNC_BYTE, clear the byte index and the running sum, then go to PAYLOAD.
  - PAYLOAD: each byte is written to shadow[idx/2] (MSB when idx is even) and added to the sum. idx counts 0..15 (4-bit). When idx=15 is accepted, go to CHECK.
  - CHECK: on the next byte, compare it with the sum.
    - Equal: copy all 8 shadows to v0..v7 at that clock edge, pulse frame_ok, go to IDLE.
    - Not equal: v0..v7 unchanged, pulse frame_err, go to IDLE.
- Inside PAYLOAD and CHECK, a byte equal to SYNC_BYTE is treated as data. There is no mid-frame resync.
- Latency: the checksum byte is sampled at edge N. v0..v7 and frame_ok are updated at edge N and visible in cycle N+1. frame_ok is high for exactly 1 cycle.
- A new frame's sync byte may arrive on the cycle immediately after the checksum byte; it is accepted in IDLE.
- Shadow registers are not visible on the outputs. A discarded frame leaves stale shadow contents, which are always fully overwritten by the next frame.
- Reset (reset==0 at an edge), including mid-frame:
  - v0..v7 = RESET_DUTY; frame_ok = frame_err = 0; busy = 0.
  - state = IDLE; idx = 0; sum = 0; shadows = RESET_DUTY.
  - Any partial frame is lost.
- rx_valid=0 cycles leave all state unchanged (timeout logic excepted).
- busy = 1 from the edge after sync is accepted until the edge that accepts the checksum byte.

Optional Feature:
FRAME_TIMEOUT_EN
- Defined:
  - A counter runs while in PAYLOAD or CHECK. It is cleared on every accepted byte and counts cycles with rx_valid=0.
  - When the count reaches TIMEOUT_CYCLES: abort, pulse frame_err, go to IDLE; v0..v7 unchanged.
  - If rx_valid arrives on the same cycle the limit is reached, the byte wins and there is no timeout.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- Not defined: no counter. The FSM waits indefinitely for the next byte.

Test Plan:
1. Reset check: reset=0 for 2 cycles, then 1 -> v0..v7=16'h0000, busy=0, no pulses.
2. Good frame: A5, 12 34, then 14 bytes of 00, checksum 46 -> after checksum edge, v0=16'h1234, v1..v7=0, frame_ok 1 cycle, busy falls; outputs unchanged before that edge.
3. Bad checksum: same frame with checksum 47 -> frame_err pulse; v0 keeps its previous value; the next good frame commits normally.
4. Embedded sync and back-to-back: payload all A5 with checksum 50 (16*A5 mod 256), sent on consecutive cycles, immediately followed by a second frame -> v0..v7=16'hA5A5, then second frame commits; frame_ok pulses for both.
5. Reset mid-frame: reset=0 after 7 payload bytes, then a full good frame (ch7=16'hFFFF, checksum FE) -> v7=16'hFFFF, v0..v6=0; the partial frame has no effect.
6. FRAME_TIMEOUT_EN with TIMEOUT_CYCLES=10: A5 plus 3 bytes, then idle -> frame_err pulses after 10 idle cycles, state IDLE, outputs unchanged; byte on 10th cycle -> no timeout.
